// File: rtl/if_stage.sv
// Instruction-fetch stage: one-outstanding-request fetch FSM driving the IF/ID
// register, with a stall hold buffer and redirect/flush handling.
`timescale 1ns/1ps
module if_stage #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic [63:0] pc_out,
    output logic        inst_valid
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DROP  = 2'd3
    } state_t;

    state_t      state_r, state_nxt_s;
    logic [63:0] pc_r, pc_nxt_s;
    logic [63:0] pc_out_r, pc_out_nxt_s;
    logic [31:0] hold_r, hold_nxt_s;
    logic [31:0] inst_r, inst_nxt_s;
    logic        valid_r, valid_nxt_s;

    // Next-state, PC, hold buffer and IF/ID register update
    always_comb begin
        state_nxt_s  = state_r;
        pc_nxt_s     = pc_r;
        hold_nxt_s   = hold_r;
        pc_out_nxt_s = pc_out_r;
        if (stall) begin
            inst_nxt_s  = inst_r;
            valid_nxt_s = valid_r;
        end else begin
            inst_nxt_s  = NOP_INST;
            valid_nxt_s = 1'b0;
        end

        if (redirect) begin
            pc_nxt_s    = redirect_pc & ~64'd3;
            inst_nxt_s  = NOP_INST;
            valid_nxt_s = 1'b0;
            hold_nxt_s  = 32'd0;
            // A request issued this very cycle (FETCH) is still in flight and must be drained
            if (state_r == FETCH) begin
                state_nxt_s = DROP;
            end else if ((state_r == HOLD) || imem_rvalid) begin
                state_nxt_s = FETCH;
            end else begin
                state_nxt_s = DROP;
            end
        end else begin
            case (state_r)
                FETCH: state_nxt_s = WAIT;
                WAIT: begin
                    if (imem_rvalid) begin
                        pc_nxt_s = pc_r + 64'd4;
                        if (stall) begin
                            hold_nxt_s  = imem_rdata;
                            state_nxt_s = HOLD;
                        end else begin
                            inst_nxt_s   = imem_rdata;
                            pc_out_nxt_s = pc_r;
                            valid_nxt_s  = 1'b1;
                            state_nxt_s  = FETCH;
                        end
                    end else begin
                        state_nxt_s = WAIT;
                    end
                end
                HOLD: begin
                    // pc already advanced past the buffered instruction
                    if (!stall) begin
                        inst_nxt_s   = hold_r;
                        pc_out_nxt_s = pc_r - 64'd4;
                        valid_nxt_s  = 1'b1;
                        state_nxt_s  = FETCH;
                    end else begin
                        state_nxt_s = HOLD;
                    end
                end
                DROP: begin
                    if (imem_rvalid) begin
                        state_nxt_s = FETCH;
                    end else begin
                        state_nxt_s = DROP;
                    end
                end
                default: state_nxt_s = FETCH;
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= FETCH;
            pc_r     <= RESET_PC;
            pc_out_r <= 64'd0;
            hold_r   <= 32'd0;
            inst_r   <= NOP_INST;
            valid_r  <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            pc_r     <= pc_nxt_s;
            pc_out_r <= pc_out_nxt_s;
            hold_r   <= hold_nxt_s;
            inst_r   <= inst_nxt_s;
            valid_r  <= valid_nxt_s;
        end
    end

    // Reset state is FETCH, so the request is masked while reset is held
    assign imem_req   = (state_r == FETCH) & rst;
    assign imem_addr  = pc_r;
    assign inst       = inst_r;
    assign pc_out     = pc_out_r;
    assign inst_valid = valid_r;

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 64'h0, SHALL set the PC value loaded on reset.
REQ-002 Parameter NOP_INST, default 32'h0000_0013 (addi x0,x0,0), SHALL set the instruction word presented on a bubble.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset; asynchronous, active-low.
REQ-005 stall  input  1  SHALL be the hold request from decode/hazard logic; 1 = IF/ID register frozen.
REQ-006 redirect  input  1  SHALL be the taken branch/jump/flush strobe, one cycle.
REQ-007 redirect_pc  input  64  SHALL be the new fetch target, valid when redirect=1.
REQ-008 imem_req  output  1  SHALL be the instruction-memory read request, one cycle per fetch.
REQ-009 imem_addr  output  64  SHALL be the fetch address, valid when imem_req=1.
REQ-010 imem_rvalid  input  1  SHALL be the memory response strobe, at least 1 cycle after imem_req.
REQ-011 imem_rdata  input  32  SHALL be the fetched instruction, valid when imem_rvalid=1.
REQ-012 inst  output  32  SHALL be the registered instruction word delivered to decode.
REQ-013 pc_out  output  64  SHALL be the registered address of inst.
REQ-014 inst_valid  output  1  SHALL be 1 when inst/pc_out hold a real fetched instruction.

Function
REQ-015 FSM states SHALL be FETCH, WAIT, HOLD, DROP; exactly one outstanding memory request at any time.
REQ-016 FETCH: imem_req=1, imem_addr=pc; next state WAIT.
REQ-017 WAIT: imem_req=0; on imem_rvalid with stall=0, load inst<=imem_rdata, pc_out<=pc, inst_valid<=1, pc<=pc+4, go FETCH.
REQ-018 WAIT: on imem_rvalid with stall=1, capture imem_rdata into a 32-bit hold buffer, pc<=pc+4, go HOLD; IF/ID register unchanged.
REQ-019 HOLD: imem_req=0; when stall=0, load IF/ID from hold buffer (pc_out = pc-4), inst_valid<=1, go FETCH.
REQ-020 Whenever no new instruction is loaded and stall=0, the IF/ID register SHALL receive NOP_INST with inst_valid=0; pc_out unchanged.
REQ-021 stall=1 SHALL hold inst, pc_out, inst_valid unchanged.
REQ-022 redirect=1 SHALL take priority over stall and any response: pc<={redirect_pc[63:2],2'b00}, inst<=NOP_INST, inst_valid<=0, hold buffer discarded.
REQ-023 Redirect in WAIT without imem_rvalid same cycle SHALL go DROP; redirect in WAIT with imem_rvalid, or in FETCH/HOLD/DROP-with-rvalid, SHALL go FETCH.
REQ-024 Redirect in FETCH SHALL still issue that cycle's imem_req for the old pc; its response is handled via DROP (next state DROP, not FETCH).
REQ-025 DROP: imem_req=0; on imem_rvalid discard data, go FETCH; IF/ID stays NOP/invalid.
REQ-026 PC arithmetic SHALL be 64-bit unsigned, wrapping 64'hFFFF_FFFF_FFFF_FFFC+4 -> 0.
REQ-027 Fetch-to-decode latency SHALL be 1 + memory latency + 1 cycles with no stall.

Reset
REQ-028 While rst=0: pc=RESET_PC, state=FETCH, inst=NOP_INST, pc_out=0, inst_valid=0, hold buffer=0, imem_req=0.
REQ-029 First imem_req (addr=RESET_PC) SHALL occur in the first cycle after rst deasserts; responses arriving during or after reset for pre-reset requests SHALL be ignored until the first post-reset request.

Verification
REQ-030 Reset release, 1-cycle memory, RESET_PC=0 -> imem_addr 0,4,8 every 2 cycles; inst_valid=1 with pc_out 0 three cycles after release.
REQ-031 stall=1 for 3 cycles while response 0x00500093 arrives -> inst unchanged during stall, then 0x00500093 with correct pc_out, no refetch.
REQ-032 redirect to 0x1003 during WAIT, response 0xDEADBEEF arrives next cycle -> response dropped, next imem_addr=0x1000, inst_valid=0 meanwhile.
REQ-033 redirect and stall same cycle -> inst=NOP_INST, inst_valid=0, pc=redirect target.
REQ-034 RESET_PC=64'hFFFF_FFFF_FFFF_FFFC -> second fetch address 0.
REQ-035 rst asserted in WAIT -> outputs to reset values immediately; late imem_rvalid ignored.
